instr_loader: RTL and testbench
===============================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001: Parameter ADDR_W, default 8, instruction-memory word-address width; capacity DEPTH = 2**ADDR_W words.
REQ-002: clk  input  1  rising-edge clock.
REQ-003: reset  input  1  reset, synchronous, active-high.
REQ-004: start  input  1  begins a load session from word address 0; honoured only in IDLE.
REQ-005: in_valid  input  1  instruction request valid.
REQ-006: in_ready  output  1  loader accepts a request this cycle.
REQ-007: in_op  input  5  mnemonic code: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 nor, 6 slt, 7 sll, 8 srl, 9 sra, 10 addi, 11 andi, 12 ori, 13 xori, 14 lw, 15 sw; codes 16-31 illegal.
REQ-008: in_rs, in_rt, in_rd, in_shamt  input  5 each  instruction fields.
REQ-009: in_imm  input  16  immediate/offset.
REQ-010: in_last  input  1  request is the final instruction of the session.
REQ-011: mem_we  output  1  instruction-memory write strobe.
REQ-012: mem_addr  output  ADDR_W  write word address.
REQ-013: mem_wdata  output  32  encoded MIPS instruction word.
REQ-014: done  output  1  one-cycle pulse at session end.
REQ-015: count  output  ADDR_W+1  words written in the current/last session.
REQ-016: err  output  1  sticky: an illegal op was received this session.
REQ-017: ovf  output  1  sticky: session was force-terminated at full capacity.

Function
REQ-018: FSM states IDLE, LOAD, DONE; IDLE->LOAD on start; LOAD->DONE after accepting a request with in_last=1 or after accepting the write at address DEPTH-1; DONE->IDLE unconditionally next cycle.
REQ-019: in_ready SHALL be 1 exactly when state is LOAD; a transfer occurs on in_valid & in_ready.
REQ-020: Entry to LOAD SHALL clear the address counter, count, err and ovf.
REQ-021: Latency: an accepted legal request SHALL appear as mem_we=1 with mem_addr/mem_wdata registered on the following cycle; mem_we SHALL be 0 at all other times.
REQ-022: R-type encoding: {6'b000000, rs, rt, rd, shamt, funct}; funct add 0x20, sub 0x22, and 0x24, or 0x25, xor 0x26, nor 0x27, slt 0x2A, sll 0x00, srl 0x02, sra 0x03.
REQ-023: Shift ops SHALL force the rs field to 0; non-shift R-type ops SHALL force the shamt field to 0.
REQ-024: I-type encoding: {opcode, rs, rt, imm}; opcode addi 0x08, andi 0x0C, ori 0x0D, xori 0x0E, lw 0x23, sw 0x2B; in_rd and in_shamt ignored.
REQ-025: Each legal accepted request SHALL increment the address counter and count by 1 after its write; addresses SHALL be strictly sequential from 0.
REQ-026: An illegal op SHALL be accepted and dropped: no write, no address/count increment, err set; if it carries in_last the session still ends normally.
REQ-027: Accepting a legal non-last request at address DEPTH-1 SHALL write it, set ovf, and end the session; the address SHALL never wrap.
REQ-028: done SHALL pulse in the DONE state, coinciding with or following the final write's mem_we, never preceding it.
REQ-029: start asserted in LOAD or DONE SHALL be ignored; count, err, ovf SHALL hold their values in IDLE until the next start.

Reset
REQ-030: On reset: state IDLE, in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, done 0, count 0, err 0, ovf 0.
REQ-031: Reset mid-session SHALL abort immediately; no write SHALL issue in the cycle after reset even if a request was accepted in the reset cycle.

Verification
REQ-032: start; add rs=1 rt=2 rd=3 shamt=9, last=0 -> next cycle mem_we=1, addr 0, wdata 0x00221820.
REQ-033: lw rs=4 rt=5 imm=0x0010 then sll rs=7 rt=1 rd=2 shamt=4 last=1 -> writes 0x8C850010 @0, 0x00011100 @1; done pulse; count=2; err=0.
REQ-034: op=20 (illegal) between two legal ops -> only two writes at addrs 0,1; err=1; count=2.
REQ-035: ADDR_W=2, five legal non-last requests -> writes at 0..3 only, ovf=1, done pulse, in_ready 0 for the fifth.
REQ-036: reset asserted the cycle a request is accepted at addr 2 -> no subsequent mem_we; all outputs 0; new start writes from addr 0.
REQ-037: start pulsed during LOAD with in_valid toggling -> addresses continue sequentially, counter not cleared.

Source files
------------

// File: rtl/instr_loader.sv
// instr_loader: accepts mnemonic-level instruction requests and writes encoded
// MIPS words sequentially into instruction memory, one session per start.
module instr_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [15:0]       in_imm,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic              err,
    output logic              ovf
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
    state_t state, state_next;
    logic [ADDR_W-1:0] addr;
    logic [5:0] code;
    logic [31:0] word;
    logic xfer, legal, full, shift, rtype;
    assign xfer  = in_valid && state == LOAD;
    assign legal = ~in_op[4];
    assign full  = addr == {ADDR_W{1'b1}};
    assign rtype = in_op < 5'd10;
    assign shift = in_op >= 5'd7 && in_op <= 5'd9;
    // code doubles as R-type funct or I-type opcode depending on op class
    always_comb begin
        code = 6'h00;
        case (in_op)
            5'd0:  code = 6'h20;
            5'd1:  code = 6'h22;
            5'd2:  code = 6'h24;
            5'd3:  code = 6'h25;
            5'd4:  code = 6'h26;
            5'd5:  code = 6'h27;
            5'd6:  code = 6'h2A;
            5'd7:  code = 6'h00;
            5'd8:  code = 6'h02;
            5'd9:  code = 6'h03;
            5'd10: code = 6'h08;
            5'd11: code = 6'h0C;
            5'd12: code = 6'h0D;
            5'd13: code = 6'h0E;
            5'd14: code = 6'h23;
            5'd15: code = 6'h2B;
            default: code = 6'h00;
        endcase
        word = rtype ? {6'b000000, shift ? 5'd0 : in_rs, in_rt, in_rd, shift ? in_shamt : 5'd0, code}
                     : {code, in_rs, in_rt, in_imm};
    end
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: state_next = start ? LOAD : IDLE;
            LOAD: begin
                in_ready = 1'b1;
                if (xfer && (in_last || (legal && full))) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            addr      <= '0;
            count     <= '0;
            err       <= 1'b0;
            ovf       <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state  <= state_next;
            mem_we <= xfer && legal;
            if (state == IDLE && start) begin
                addr  <= '0;
                count <= '0;
                err   <= 1'b0;
                ovf   <= 1'b0;
            end
            if (xfer && !legal) err <= 1'b1;
            // the last slot is written but the address holds so it never wraps
            if (xfer && legal) begin
                mem_addr  <= addr;
                mem_wdata <= word;
                count     <= count + 1'b1;
                if (!full) addr <= addr + 1'b1;
                if (full && !in_last) ovf <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: directed vectors feed a write scoreboard; a negedge monitor
// pops and compares every mem_we beat.
module tb_instr_loader;
    logic clk = 0, reset = 1, start = 0, in_valid = 0, in_last = 0;
    logic [4:0] in_op = 0, in_rs = 0, in_rt = 0, in_rd = 0, in_shamt = 0;
    logic [15:0] in_imm = 0;
    logic in_ready, mem_we, done, err, ovf;
    logic [1:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0] count;
    logic [63:0] q[$];
    logic [31:0] exp_addr;
    int npass = 0, ntot = 0;

    instr_loader #(.ADDR_W(2)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_imm(in_imm), .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .done(done), .count(count), .err(err), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        ntot++;
        if (a === e) npass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", n, a, e);
    endtask

    always @(negedge clk) begin
        if (mem_we) begin
            if (q.size() == 0) chk("unexpected_write", {30'd0, mem_addr}, 32'hFFFFFFFF);
            else begin
                logic [63:0] e;
                e = q.pop_front();
                chk("wr_addr", {30'd0, mem_addr}, e[63:32]);
                chk("wr_data", mem_wdata, e[31:0]);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start;
        start = 1;
        tick();
        start = 0;
        exp_addr = 0;
    endtask

    task automatic send(input logic [4:0] op, rs, rt, rd, sh, input logic [15:0] imm,
                        input logic last, input logic lg, input logic [31:0] w);
        logic ok;
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh; in_imm = imm;
        in_last = last; in_valid = 1; ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (in_ready) ok = 1;
            else tick();
        end
        chk("accept", {31'd0, ok}, 32'd1);
        if (ok) begin
            if (lg) begin
                q.push_back({exp_addr, w});
                exp_addr++;
            end
            tick();
        end
        in_valid = 0; in_last = 0;
    endtask

    task automatic end_chk(input logic [31:0] c, input logic e, input logic o);
        chk("done_pulse", {31'd0, done}, 32'd1);
        tick();
        chk("done_clear", {31'd0, done}, 32'd0);
        chk("count", {29'd0, count}, c);
        chk("err", {31'd0, err}, {31'd0, e});
        chk("ovf", {31'd0, ovf}, {31'd0, o});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        reset = 0;
        chk("rst_ready", {31'd0, in_ready}, 0);
        chk("rst_we", {31'd0, mem_we}, 0);
        chk("rst_addr", {30'd0, mem_addr}, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_count", {29'd0, count}, 0);
        chk("rst_err_ovf", {30'd0, err, ovf}, 0);
        // add with shamt forced to 0, then xori
        do_start();
        chk("load_ready", {31'd0, in_ready}, 1);
        send(0, 1, 2, 3, 9, 0, 0, 1, 32'h00221820);
        send(13, 3, 4, 0, 0, 16'hBEEF, 1, 1, 32'h3864BEEF);
        end_chk(2, 0, 0);
        repeat (2) tick();
        chk("idle_count_hold", {29'd0, count}, 2);
        // lw then sll with rs forced to 0
        do_start();
        send(14, 4, 5, 0, 0, 16'h0010, 0, 1, 32'h8C850010);
        send(7, 7, 1, 2, 4, 0, 1, 1, 32'h00011100);
        end_chk(2, 0, 0);
        // illegal op dropped between two legal ops
        do_start();
        send(3, 31, 0, 17, 5, 0, 0, 1, 32'h03E08825);
        send(20, 1, 1, 1, 1, 16'h1234, 0, 0, 0);
        send(9, 9, 6, 10, 31, 0, 1, 1, 32'h000657C3);
        end_chk(2, 1, 0);
        tick();
        chk("err_sticky_idle", {31'd0, err}, 1);
        // capacity overflow at DEPTH=4
        do_start();
        chk("err_cleared", {31'd0, err}, 0);
        for (int k = 0; k < 4; k++) send(10, 1, 2, 0, 0, 16'(k), 0, 1, 32'h20220000 + k);
        chk("ovf_ready_off", {31'd0, in_ready}, 0);
        in_op = 10; in_valid = 1;
        chk("done_pulse", {31'd0, done}, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("fifth_not_ready", {31'd0, in_ready}, 0);
        end
        in_valid = 0;
        chk("ovf_count", {29'd0, count}, 4);
        chk("ovf_flag", {31'd0, ovf}, 1);
        // reset in the cycle a request at addr 2 is accepted
        do_start();
        chk("ovf_cleared", {31'd0, ovf}, 0);
        send(5, 1, 2, 3, 0, 0, 0, 1, 32'h00221827);
        send(6, 2, 3, 4, 0, 0, 0, 1, 32'h0043202A);
        in_op = 0; in_rs = 1; in_valid = 1; reset = 1;
        tick();
        reset = 0; in_valid = 0;
        chk("abort_we", {31'd0, mem_we}, 0);
        chk("abort_addr", {30'd0, mem_addr}, 0);
        chk("abort_wdata", mem_wdata, 0);
        chk("abort_flags", {28'd0, in_ready, done, err, ovf}, 0);
        chk("abort_count", {29'd0, count}, 0);
        tick();
        chk("abort_we2", {31'd0, mem_we}, 0);
        do_start();
        send(2, 5, 6, 7, 0, 0, 1, 1, 32'h00A63824);
        end_chk(1, 0, 0);
        // start ignored mid-session while in_valid toggles
        do_start();
        send(8, 0, 8, 9, 2, 0, 0, 1, 32'h00084882);
        start = 1;
        tick();
        start = 0;
        tick();
        start = 1;
        send(15, 29, 31, 0, 0, 16'hFFFC, 0, 1, 32'hAFBFFFFC);
        start = 0;
        tick();
        send(1, 1, 1, 1, 0, 0, 1, 1, 32'h00210822);
        end_chk(3, 0, 0);
        repeat (3) tick();
        chk("sb_empty", q.size(), 0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
